// File: rtl/stream_arb_pkg.sv
// Shared types and constants for the multi-channel stream arbiter.
package stream_arb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    SCAN  = 3'd2,
    XFER  = 3'd3,
    FLUSH = 3'd4
  } arb_state_e;

  localparam logic       MODE_SEQ  = 1'b0;
  localparam logic       MODE_RR   = 1'b1;
  localparam logic [7:0] HDR_MAGIC = 8'hA5;

endpackage

// File: rtl/rr_pick_nch.sv
// Combinational picker: first eligible index strictly after base, wrapping.
// A base of NUM_CH-1 yields the lowest eligible index.
module rr_pick_nch #(
  parameter int NUM_CH = 8,
  parameter int IDX_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] elig,
  input  logic [IDX_W-1:0]  base,
  output logic [IDX_W-1:0]  idx,
  output logic              found
);

  always_comb begin
    int j;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      j = int'(base) + 1 + k;
      if (j >= NUM_CH) j = j - NUM_CH;
      if (!found && elig[j]) begin
        found = 1'b1;
        idx   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/stream_arbiter_nch.sv
// Drains up to NUM_CH FWFT FIFOs into one registered ready/valid stream.
// Optional leading header word per transaction: define STREAM_ARB_HEADER_EN.
module stream_arbiter_nch
  import stream_arb_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [NUM_CH-1:0]        ch_select,
  input  logic [CNT_W-1:0]         num_words,
  input  logic                     mode,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_rd_en,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     done
);

  localparam int              IDX_W    = $clog2(NUM_CH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

  arb_state_e          state, state_d;
  logic [NUM_CH-1:0]   sel_q;
  logic [CNT_W-1:0]    nw_q;
  logic                mode_q;
  logic [IDX_W-1:0]    cur;
  logic [CNT_W-1:0]    cnt [NUM_CH];

  logic [DATA_W-1:0]   data_p1;
  logic                vld_p1;
  logic                done_q;

  logic                load_ok;
  logic [NUM_CH-1:0]   elig;
  logic [IDX_W-1:0]    pick_base, pick_idx;
  logic                pick_found;
  logic [CNT_W-1:0]    cnt_cur, cnt_inc;
  logic [DATA_W-1:0]   word_cur;
  logic                pop, latch, done_d;
`ifdef STREAM_ARB_HEADER_EN
  logic                hdr_ld;

  if (DATA_W < NUM_CH + CNT_W + 9) begin : g_hdr_width_chk
    $error("stream_arbiter_nch: DATA_W too narrow for header word");
  end

  function automatic logic [DATA_W-1:0] make_hdr(input logic [NUM_CH-1:0] s,
                                                  input logic [CNT_W-1:0]  n,
                                                  input logic              m);
    logic [DATA_W-1:0] h;
    h                  = '0;
    h[DATA_W-1 -: 8]   = HDR_MAGIC;
    h[DATA_W-9]        = m;
    h[NUM_CH +: CNT_W] = n;
    h[NUM_CH-1:0]      = s;
    return h;
  endfunction
`endif

  assign load_ok  = ~vld_p1 | out_ready;
  assign cnt_cur  = cnt[cur];
  assign cnt_inc  = cnt_cur + CNT_W'(1);
  assign word_cur = in_data[int'(cur)*DATA_W +: DATA_W];

  always_comb begin
    elig = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      elig[c] = sel_q[c] & (cnt[c] != nw_q);
    end
  end

  // Sequential mode always restarts the search from index 0.
  assign pick_base = (mode_q == MODE_RR) ? cur : LAST_IDX;

  rr_pick_nch #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_pick (
    .elig  (elig),
    .base  (pick_base),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d  = state;
    in_rd_en = '0;
    pop      = 1'b0;
    latch    = 1'b0;
    done_d   = 1'b0;
`ifdef STREAM_ARB_HEADER_EN
    hdr_ld   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          latch = 1'b1;
`ifdef STREAM_ARB_HEADER_EN
          state_d = HDR;
`else
          state_d = SCAN;
`endif
        end
      end
`ifdef STREAM_ARB_HEADER_EN
      HDR: begin
        if (load_ok) begin
          hdr_ld  = 1'b1;
          state_d = SCAN;
        end
      end
`endif
      SCAN: state_d = pick_found ? XFER : FLUSH;
      XFER: begin
        pop           = in_valid[cur] & load_ok & (cnt_cur != nw_q);
        in_rd_en[cur] = pop;
        // Round-robin yields after every cycle so an empty channel never stalls the rest.
        if (mode_q == MODE_RR)
          state_d = SCAN;
        else if ((cnt_cur == nw_q) || (pop && (cnt_inc == nw_q)))
          state_d = SCAN;
      end
      FLUSH: begin
        if (!vld_p1 || out_ready) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage p1: output register, transaction context and per-channel counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q   <= '0;
      nw_q    <= '0;
      mode_q  <= MODE_SEQ;
      cur     <= '0;
      data_p1 <= '0;
      vld_p1  <= 1'b0;
      done_q  <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) cnt[c] <= '0;
    end else begin
      done_q <= done_d;
      if (latch) begin
        sel_q  <= ch_select;
        nw_q   <= num_words;
        mode_q <= mode;
        cur    <= LAST_IDX;
        for (int c = 0; c < NUM_CH; c++) cnt[c] <= '0;
      end
      if ((state == SCAN) && pick_found) cur <= pick_idx;
      if (pop) cnt[cur] <= cnt_inc;

      if (pop) begin
        data_p1 <= word_cur;
        vld_p1  <= 1'b1;
      end
`ifdef STREAM_ARB_HEADER_EN
      else if (hdr_ld) begin
        data_p1 <= make_hdr(sel_q, nw_q, mode_q);
        vld_p1  <= 1'b1;
      end
`endif
      else if (out_ready) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign out_data  = data_p1;
  assign out_valid = vld_p1;
  assign done      = done_q;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_stream_arbiter_nch.sv
// Self-checking bench for stream_arbiter_nch: queue-based FIFO model and
// expected output order derived from the drain rules.
module tb_stream_arbiter_nch;

  localparam int N  = 8;
  localparam int DW = 32;
  localparam int CW = 8;
`ifdef STREAM_ARB_HEADER_EN
  localparam int HX = 1;
`else
  localparam int HX = 0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [N-1:0]    ch_select = '0;
  logic [CW-1:0]   num_words = '0;
  logic            mode = 1'b0;
  logic [N*DW-1:0] in_data = '0;
  logic [N-1:0]    in_valid = '0;
  logic [N-1:0]    in_rd_en;
  logic [DW-1:0]   out_data;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic            busy;
  logic            done;

  always #5 clk = ~clk;

  stream_arbiter_nch #(.NUM_CH(N), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .ch_select (ch_select),
    .num_words (num_words),
    .mode      (mode),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_rd_en  (in_rd_en),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  logic [DW-1:0] fifo [N][$];
  logic [DW-1:0] src  [N][$];
  logic [DW-1:0] got  [$];
  logic [DW-1:0] expq [$];
  int pops [N];
  int first_rd, first_vld, done_cyc, done_cnt, proto_bad, hold_bad, busy_bad;
  int total = 0;
  int bad   = 0;

  task automatic fill(input int nwords);
    logic [3:0]  c4;
    logic [11:0] i12;
    logic [15:0] r16;
    for (int c = 0; c < N; c++) begin
      fifo[c].delete();
      src[c].delete();
      for (int i = 0; i < nwords + 2; i++) begin
        c4  = 4'(c);
        i12 = 12'(i);
        r16 = 16'($urandom);
        fifo[c].push_back({c4, i12, r16});
        src[c].push_back({c4, i12, r16});
      end
    end
  endtask

  // Drive one transaction and record what the DUT did; starts and ends at posedge+1.
  task automatic run(input logic [N-1:0] sel, input int nw, input logic md, input int vprob,
                     input int rpat, input int hold0, input bit restart, input int budget);
    logic stall;
    logic [DW-1:0] pd;
    fill(nw);
    got.delete();
    for (int c = 0; c < N; c++) pops[c] = 0;
    first_rd = -1; first_vld = -1; done_cyc = -1; done_cnt = 0;
    proto_bad = 0; hold_bad = 0; busy_bad = 0;
    stall = 1'b0; pd = '0;
    ch_select = sel; num_words = CW'(nw); mode = md; start = 1'b1;
    for (int cyc = 0; cyc < budget; cyc++) begin
      if (cyc == 1) begin
        start = restart;
        ch_select = ~sel; num_words = CW'(nw + 1); mode = ~md;
      end else if (cyc >= 2) begin
        start = 1'b0;
      end
      for (int c = 0; c < N; c++) begin
        in_valid[c] = (fifo[c].size() > 0) && (c != 0 || cyc >= hold0) &&
                      ($urandom_range(99) < vprob);
        in_data[c*DW +: DW] = (fifo[c].size() > 0) ? fifo[c][0] : '0;
      end
      out_ready = (rpat == 0) ? 1'b1 : (rpat == 1) ? (cyc % 2 == 0) : 1'($urandom_range(1));
      @(negedge clk);
      if (stall && (!out_valid || out_data !== pd)) hold_bad++;
      if (in_rd_en != '0) begin
        if (first_rd < 0) first_rd = cyc;
        if ($countones(in_rd_en) != 1 || (in_rd_en & ~in_valid) != '0 ||
            (out_valid && !out_ready)) proto_bad++;
        for (int c = 0; c < N; c++)
          if (in_rd_en[c]) begin
            pops[c]++;
            if (fifo[c].size() > 0) void'(fifo[c].pop_front());
          end
      end
      if (out_valid && first_vld < 0) first_vld = cyc;
      if (out_valid && out_ready) got.push_back(out_data);
      if (cyc == 0 && busy) busy_bad++;
      if (cyc >= 1 && done_cyc < 0 && !done && !busy) busy_bad++;
      if (done && busy) busy_bad++;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      stall = out_valid && !out_ready;
      pd    = out_data;
      @(posedge clk); #1;
      if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
    end
    start = 1'b0;
    in_valid = '0;
  endtask

  task automatic build_exp(input logic [N-1:0] sel, input int nw, input logic md);
    logic [DW-1:0] h;
    expq.delete();
    if (HX != 0) begin
      h = 32'hA500_0000;
      h[23] = md;
      h[15:8] = CW'(nw);
      h[7:0] = sel;
      expq.push_back(h);
    end
    if (md == 1'b0) begin
      for (int c = 0; c < N; c++)
        if (sel[c]) for (int i = 0; i < nw; i++) expq.push_back(src[c][i]);
    end else begin
      for (int i = 0; i < nw; i++)
        for (int c = 0; c < N; c++)
          if (sel[c]) expq.push_back(src[c][i]);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (in_rd_en !== '0) begin bad++; $display("FAIL reset_rd_en got=%h exp=0", in_rd_en); end
    total++; if (out_valid !== 1'b0 || out_data !== '0) begin bad++;
      $display("FAIL reset_out got vld=%b data=%h exp 0/0", out_valid, out_data); end
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++;
      $display("FAIL reset_busy_done got busy=%b done=%b exp 0/0", busy, done); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_mode0;
    int others;
    run(8'b0000_0101, 3, 1'b0, 100, 0, 0, 1'b1, 200);
    build_exp(8'b0000_0101, 3, 1'b0);
    total++; if (got.size() != expq.size()) begin bad++;
      $display("FAIL mode0_len got=%0d exp=%0d", got.size(), expq.size()); end
    for (int i = 0; i < expq.size() && i < got.size(); i++) begin
      total++; if (got[i] !== expq[i]) begin bad++;
        $display("FAIL mode0_word[%0d] got=%h exp=%h", i, got[i], expq[i]); end
    end
    others = 0;
    for (int c = 0; c < N; c++) if (c != 0 && c != 2) others += pops[c];
    total++; if (pops[0] != 3 || pops[2] != 3 || others != 0) begin bad++;
      $display("FAIL mode0_pops got ch0=%0d ch2=%0d other=%0d exp 3/3/0", pops[0], pops[2], others); end
    total++; if (first_rd != 2 + HX) begin bad++;
      $display("FAIL mode0_first_rd got=%0d exp=%0d", first_rd, 2 + HX); end
    total++; if (first_vld != 3 - HX) begin bad++;
      $display("FAIL mode0_first_vld got=%0d exp=%0d", first_vld, 3 - HX); end
    total++; if (done_cyc != 11 + HX || done_cnt != 1) begin bad++;
      $display("FAIL mode0_done got cyc=%0d cnt=%0d exp %0d/1", done_cyc, done_cnt, 11 + HX); end
    total++; if (proto_bad != 0 || busy_bad != 0) begin bad++;
      $display("FAIL mode0_proto got proto=%0d busy=%0d exp 0/0", proto_bad, busy_bad); end
  endtask

  task automatic test_rr;
    run(8'b0000_0011, 2, 1'b1, 100, 0, 0, 1'b0, 200);
    build_exp(8'b0000_0011, 2, 1'b1);
    total++; if (got.size() != expq.size()) begin bad++;
      $display("FAIL rr_len got=%0d exp=%0d", got.size(), expq.size()); end
    for (int i = 0; i < expq.size() && i < got.size(); i++) begin
      total++; if (got[i] !== expq[i]) begin bad++;
        $display("FAIL rr_word[%0d] got=%h exp=%h", i, got[i], expq[i]); end
    end
    total++; if (done_cnt != 1 || proto_bad != 0) begin bad++;
      $display("FAIL rr_done got cnt=%0d proto=%0d exp 1/0", done_cnt, proto_bad); end
  endtask

  task automatic test_rr_stall;
    run(8'b0000_0011, 2, 1'b1, 100, 0, 10, 1'b0, 300);
    expq.delete();
    expq.push_back(src[1][0]); expq.push_back(src[1][1]);
    expq.push_back(src[0][0]); expq.push_back(src[0][1]);
    if (HX != 0) void'(got.pop_front());
    total++; if (got.size() != 4) begin bad++;
      $display("FAIL rr_stall_len got=%0d exp=4", got.size()); end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      total++; if (got[i] !== expq[i]) begin bad++;
        $display("FAIL rr_stall_word[%0d] got=%h exp=%h", i, got[i], expq[i]); end
    end
    total++; if (done_cnt != 1 || done_cyc < 10) begin bad++;
      $display("FAIL rr_stall_done got cnt=%0d cyc=%0d exp 1/>=10", done_cnt, done_cyc); end
  endtask

  task automatic test_backpressure;
    run(8'b0000_0001, 8, 1'b0, 100, 1, 0, 1'b0, 300);
    build_exp(8'b0000_0001, 8, 1'b0);
    total++; if (got.size() != expq.size() || pops[0] != 8) begin bad++;
      $display("FAIL bp_len got=%0d pops=%0d exp=%0d/8", got.size(), pops[0], expq.size()); end
    for (int i = 0; i < expq.size() && i < got.size(); i++) begin
      total++; if (got[i] !== expq[i]) begin bad++;
        $display("FAIL bp_word[%0d] got=%h exp=%h", i, got[i], expq[i]); end
    end
    total++; if (proto_bad != 0 || hold_bad != 0 || done_cnt != 1) begin bad++;
      $display("FAIL bp_proto got proto=%0d hold=%0d done=%0d exp 0/0/1", proto_bad, hold_bad, done_cnt); end
  endtask

  task automatic test_empty;
    int sum;
    for (int t = 0; t < 2; t++) begin
      if (t == 0) run(8'b0000_0000, 3, 1'b0, 100, 0, 0, 1'b1, 50);
      else        run(8'b0000_0101, 0, 1'b0, 100, 0, 0, 1'b1, 50);
      sum = 0;
      for (int c = 0; c < N; c++) sum += pops[c];
      total++; if (sum != 0 || first_rd != -1) begin bad++;
        $display("FAIL empty%0d_pops got=%0d exp=0", t, sum); end
      total++; if (got.size() != HX) begin bad++;
        $display("FAIL empty%0d_words got=%0d exp=%0d", t, got.size(), HX); end
      total++; if (done_cyc != 3 + HX || done_cnt != 1) begin bad++;
        $display("FAIL empty%0d_done got cyc=%0d cnt=%0d exp %0d/1", t, done_cyc, done_cnt, 3 + HX); end
    end
  endtask

  task automatic test_max_words;
    run(8'b1000_0000, 255, 1'b0, 100, 0, 0, 1'b0, 400);
    build_exp(8'b1000_0000, 255, 1'b0);
    total++; if (got.size() != expq.size() || pops[7] != 255) begin bad++;
      $display("FAIL max_len got=%0d pops=%0d exp=%0d/255", got.size(), pops[7], expq.size()); end
    for (int i = 0; i < expq.size() && i < got.size(); i++) begin
      total++; if (got[i] !== expq[i]) begin bad++;
        $display("FAIL max_word[%0d] got=%h exp=%h", i, got[i], expq[i]); end
    end
    total++; if (done_cyc != 259 + HX) begin bad++;
      $display("FAIL max_done got=%0d exp=%0d", done_cyc, 259 + HX); end
  endtask

  task automatic test_random;
    logic [N-1:0] sel;
    logic md;
    int nw, k;
    for (int t = 0; t < 6; t++) begin
      sel = N'($urandom);
      nw  = $urandom_range(5, 1);
      md  = 1'($urandom_range(1));
      run(sel, nw, md, $urandom_range(100, 50), 2, 0, 1'b0, 600);
      if (md == 1'b0) begin
        build_exp(sel, nw, md);
        total++; if (got.size() != expq.size()) begin bad++;
          $display("FAIL rand%0d_len got=%0d exp=%0d", t, got.size(), expq.size()); end
        for (int i = 0; i < expq.size() && i < got.size(); i++) begin
          total++; if (got[i] !== expq[i]) begin bad++;
            $display("FAIL rand%0d_word[%0d] got=%h exp=%h", t, i, got[i], expq[i]); end
        end
      end else begin
        for (int c = 0; c < N; c++) begin
          k = 0;
          for (int i = 0; i < got.size(); i++) begin
            if (int'(got[i][31:28]) == c) begin
              total++; if (k >= nw || got[i] !== src[c][k]) begin bad++;
                $display("FAIL rand%0d_ch%0d[%0d] got=%h", t, c, k, got[i]); end
              k++;
            end
          end
          total++; if (k != (sel[c] ? nw : 0)) begin bad++;
            $display("FAIL rand%0d_ch%0d_cnt got=%0d exp=%0d", t, c, k, sel[c] ? nw : 0); end
        end
      end
      total++; if (done_cnt != 1 || proto_bad != 0 || hold_bad != 0 || busy_bad != 0) begin bad++;
        $display("FAIL rand%0d_proto got done=%0d proto=%0d hold=%0d busy=%0d exp 1/0/0/0",
                 t, done_cnt, proto_bad, hold_bad, busy_bad); end
    end
  endtask

  task automatic test_reset_mid;
    run(8'b1111_1111, 20, 1'b0, 100, 0, 0, 1'b0, 10);
    rst = 1'b1;
    #1;
    total++; if (in_rd_en !== '0 || out_valid !== 1'b0 || out_data !== '0) begin bad++;
      $display("FAIL rstmid_out got rd=%h vld=%b data=%h exp 0", in_rd_en, out_valid, out_data); end
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++;
      $display("FAIL rstmid_busy got busy=%b done=%b exp 0/0", busy, done); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run(8'b0000_0110, 2, 1'b0, 100, 0, 0, 1'b0, 200);
    build_exp(8'b0000_0110, 2, 1'b0);
    total++; if (got.size() != expq.size()) begin bad++;
      $display("FAIL rstmid_len got=%0d exp=%0d", got.size(), expq.size()); end
    for (int i = 0; i < expq.size() && i < got.size(); i++) begin
      total++; if (got[i] !== expq[i]) begin bad++;
        $display("FAIL rstmid_word[%0d] got=%h exp=%h", i, got[i], expq[i]); end
    end
    total++; if (done_cyc != 9 + HX) begin bad++;
      $display("FAIL rstmid_done got=%0d exp=%0d", done_cyc, 9 + HX); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mode0();
    test_rr();
    test_rr_stall();
    test_backpressure();
    test_empty();
    test_max_words();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
